// File: rtl/acc_repeat_ctrl.sv
// Command sequencer for the signed add/subtract accumulator: repeats acc <= acc +/- step
// until the count is exhausted, signed overflow occurs, or the command is aborted.
module acc_repeat_ctrl #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  output logic             o_ready,
  input  logic             i_op,
  input  logic [WIDTH-1:0] i_init,
  input  logic [WIDTH-1:0] i_step,
  input  logic [CNT_W-1:0] i_count,
  input  logic             i_abort,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_result,
  output logic             o_ovf,
  output logic             o_carry,
  output logic [CNT_W-1:0] o_steps
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_nxt;
  logic             op_q;
  logic [WIDTH-1:0] step_q;
  logic [CNT_W-1:0] count_q;
  logic [WIDTH-1:0] acc, acc_nxt;
  logic [CNT_W-1:0] steps, steps_nxt, steps_inc;
  logic             ovf, ovf_nxt;
  logic             carry, carry_nxt;
  logic             latch;
  logic [WIDTH-1:0] operand;
  logic [WIDTH:0]   sum;
  logic             step_ovf;

  always_comb begin
    // Subtract is acc + ~step + 1, so the carry-out reads as "no borrow".
    operand   = op_q ? ~step_q : step_q;
    sum       = {1'b0, acc} + {1'b0, operand} + {{WIDTH{1'b0}}, op_q};
    steps_inc = steps + 1'b1;
    step_ovf  = (op_q ? (acc[WIDTH-1] != step_q[WIDTH-1])
                      : (acc[WIDTH-1] == step_q[WIDTH-1]))
                && (sum[WIDTH-1] != acc[WIDTH-1]);

    state_nxt = state;
    acc_nxt   = acc;
    steps_nxt = steps;
    ovf_nxt   = ovf;
    carry_nxt = carry;
    latch     = 1'b0;

    case (state)
      IDLE: begin
        if (i_start) begin
          latch     = 1'b1;
          acc_nxt   = i_init;
          steps_nxt = '0;
          ovf_nxt   = 1'b0;
          carry_nxt = 1'b0;
          state_nxt = (i_count == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        if (i_abort) begin
          state_nxt = DONE;
        end else begin
          acc_nxt   = sum[WIDTH-1:0];
          carry_nxt = sum[WIDTH];
          steps_nxt = steps_inc;
          if (step_ovf) begin
            ovf_nxt   = 1'b1;
            state_nxt = DONE;
          end else if (steps_inc == count_q) begin
            state_nxt = DONE;
          end
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state   <= IDLE;
      acc     <= '0;
      steps   <= '0;
      ovf     <= 1'b0;
      carry   <= 1'b0;
      op_q    <= 1'b0;
      step_q  <= '0;
      count_q <= '0;
    end else begin
      state <= state_nxt;
      acc   <= acc_nxt;
      steps <= steps_nxt;
      ovf   <= ovf_nxt;
      carry <= carry_nxt;
      if (latch) begin
        op_q    <= i_op;
        step_q  <= i_step;
        count_q <= i_count;
      end
    end
  end

  assign o_ready  = (state == IDLE);
  assign o_busy   = (state == RUN);
  assign o_done   = (state == DONE);
  assign o_result = acc;
  assign o_ovf    = ovf;
  assign o_carry  = carry;
  assign o_steps  = steps;

endmodule

// File: tb/tb_acc_repeat_ctrl.sv
// Bench for acc_repeat_ctrl: table of commands plus hand sequences; completions are
// checked by a scoreboard that pops the expected result on every o_done pulse.
module tb_acc_repeat_ctrl;

  logic       i_clk = 1'b0;
  logic       i_rst = 1'b1;
  logic       i_start = 1'b0;
  logic       o_ready;
  logic       i_op = 1'b0;
  logic [7:0] i_init = '0;
  logic [7:0] i_step = '0;
  logic [3:0] i_count = '0;
  logic       i_abort = 1'b0;
  logic       o_busy, o_done, o_ovf, o_carry;
  logic [7:0] o_result;
  logic [3:0] o_steps;

  acc_repeat_ctrl #(.WIDTH(8), .CNT_W(4)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_start(i_start), .o_ready(o_ready),
    .i_op(i_op), .i_init(i_init), .i_step(i_step), .i_count(i_count),
    .i_abort(i_abort), .o_busy(o_busy), .o_done(o_done), .o_result(o_result),
    .o_ovf(o_ovf), .o_carry(o_carry), .o_steps(o_steps)
  );

  always #5 i_clk = ~i_clk;

  int cyc = 0;
  always @(posedge i_clk) cyc <= cyc + 1;

  int passed = 0;
  int total  = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
  endtask

  typedef struct {
    logic [7:0] res;
    logic       ovf;
    logic       carry;
    logic [3:0] st;
    int         done_cyc;
  } sb_t;
  sb_t sb[$];

  typedef struct {
    logic       op;
    logic [7:0] init;
    logic [7:0] step;
    logic [3:0] count;
    logic [7:0] res;
    logic       ovf;
    logic       carry;
    logic [3:0] st;
  } vec_t;
  vec_t tbl[9];

  // Behavioural reference: integer arithmetic, carry from unsigned magnitude comparison.
  function automatic void model(input logic op, input logic [7:0] init, input logic [7:0] step,
                                input logic [3:0] cnt, output logic [7:0] res, output logic ovf,
                                output logic carry, output logic [3:0] st);
    int a, b, s;
    a = $signed(init);
    b = $signed(step);
    res = init; ovf = 1'b0; carry = 1'b0; st = '0;
    for (int i = 0; i < int'(cnt); i++) begin
      s = op ? a - b : a + b;
      carry = op ? (int'(res) >= int'(step)) : ((int'(res) + int'(step)) > 255);
      res = s[7:0];
      st++;
      if (s > 127 || s < -128) begin
        ovf = 1'b1;
        break;
      end
      a = s;
    end
  endfunction

  task automatic run_cmd(input logic op, input logic [7:0] init, input logic [7:0] step,
                         input logic [3:0] cnt, input logic [7:0] res, input logic ovf,
                         input logic carry, input logic [3:0] st, input int done_off,
                         input bit push);
    int n = 0;
    while (!o_ready && n < 200) begin
      @(negedge i_clk);
      n++;
    end
    if (!o_ready) chk("ready_timeout", 32'd0, 32'd1);
    i_op = op; i_init = init; i_step = step; i_count = cnt; i_start = 1'b1;
    if (push) sb.push_back('{res, ovf, carry, st, cyc + done_off});
    @(negedge i_clk);
    i_start = 1'b0;
  endtask

  bit chk_pulse = 0;
  always @(negedge i_clk) begin
    sb_t e;
    if (chk_pulse) begin
      chk("done_pulse_width", {31'd0, o_done}, 32'd0);
      chk("ready_after_done", {31'd0, o_ready}, 32'd1);
      chk_pulse = 0;
    end else if (o_done) begin
      if (sb.size() == 0) begin
        chk("unexpected_done", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        chk("result", {24'd0, o_result}, {24'd0, e.res});
        chk("ovf", {31'd0, o_ovf}, {31'd0, e.ovf});
        chk("carry", {31'd0, o_carry}, {31'd0, e.carry});
        chk("steps", {28'd0, o_steps}, {28'd0, e.st});
        chk("done_cycle", cyc, e.done_cyc);
        chk_pulse = 1;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] r, ri, rs;
    logic       o, c, rop;
    logic [3:0] s, rc;
    int         n;

    tbl[0] = '{1'b0, 8'd17,      8'd25,     4'd3,  8'd92,  1'b0, 1'b0, 4'd3};
    tbl[1] = '{1'b0, 8'd0,       8'd93,     4'd5,  8'hBA,  1'b1, 1'b0, 4'd2};
    tbl[2] = '{1'b1, 8'(-100),   8'd37,     4'd4,  8'h77,  1'b1, 1'b1, 4'd1};
    tbl[3] = '{1'b1, 8'(-36),    8'(-27),   4'd2,  8'd18,  1'b0, 1'b1, 4'd2};
    tbl[4] = '{1'b0, 8'(-7),     8'd55,     4'd0,  8'(-7), 1'b0, 1'b0, 4'd0};
    tbl[5] = '{1'b1, 8'd0,       8'd1,      4'd15, 8'(-15),1'b0, 1'b1, 4'd15};
    tbl[6] = '{1'b0, 8'h80,      8'hFF,     4'd3,  8'h7F,  1'b1, 1'b1, 4'd1};
    tbl[7] = '{1'b0, 8'd100,     8'd1,      4'd15, 8'd115, 1'b0, 1'b0, 4'd15};
    tbl[8] = '{1'b1, 8'd127,     8'hFF,     4'd1,  8'h80,  1'b1, 1'b0, 4'd1};

    // Reset held with i_start high: nothing may be accepted.
    i_rst = 1'b1; i_start = 1'b1; i_count = 4'd3; i_init = 8'd9;
    @(negedge i_clk);
    @(negedge i_clk);
    chk("rst_ready", {31'd0, o_ready}, 32'd1);
    chk("rst_busy", {31'd0, o_busy}, 32'd0);
    chk("rst_done", {31'd0, o_done}, 32'd0);
    chk("rst_result", {24'd0, o_result}, 32'd0);
    chk("rst_ovf", {31'd0, o_ovf}, 32'd0);
    chk("rst_carry", {31'd0, o_carry}, 32'd0);
    chk("rst_steps", {28'd0, o_steps}, 32'd0);
    i_rst = 1'b0; i_start = 1'b0;
    @(negedge i_clk);
    chk("idle_after_rst", {31'd0, o_ready}, 32'd1);

    // Per-cycle trace of a plain add command.
    run_cmd(1'b0, 8'd17, 8'd25, 4'd3, 8'd92, 1'b0, 1'b0, 4'd3, 4, 1);
    chk("trace_e0_result", {24'd0, o_result}, 32'd17);
    chk("trace_busy", {31'd0, o_busy}, 32'd1);
    chk("trace_not_ready", {31'd0, o_ready}, 32'd0);
    @(negedge i_clk); chk("trace_e1", {24'd0, o_result}, 32'd42);
    @(negedge i_clk); chk("trace_e2", {24'd0, o_result}, 32'd67);
    @(negedge i_clk); chk("trace_e3", {24'd0, o_result}, 32'd92);

    for (int i = 0; i < 9; i++)
      run_cmd(tbl[i].op, tbl[i].init, tbl[i].step, tbl[i].count,
              tbl[i].res, tbl[i].ovf, tbl[i].carry, tbl[i].st, int'(tbl[i].st) + 1, 1);

    for (int i = 0; i < 8; i++) begin
      rop = 1'($urandom_range(0, 1));
      ri  = 8'($urandom_range(0, 255));
      rs  = 8'($urandom_range(0, 255));
      rc  = 4'($urandom_range(0, 15));
      model(rop, ri, rs, rc, r, o, c, s);
      run_cmd(rop, ri, rs, rc, r, o, c, s, int'(s) + 1, 1);
    end

    // Abort after E4, with an ignored start pulse during RUN.
    run_cmd(1'b0, 8'd0, 8'd1, 4'd15, 8'd4, 1'b0, 1'b0, 4'd4, 6, 1);
    @(negedge i_clk);
    i_start = 1'b1; i_init = 8'd99; i_count = 4'd1; i_op = 1'b1;
    @(negedge i_clk);
    i_start = 1'b0;
    @(negedge i_clk);
    @(negedge i_clk);
    chk("abort_pre_result", {24'd0, o_result}, 32'd4);
    chk("abort_pre_steps", {28'd0, o_steps}, 32'd4);
    i_abort = 1'b1;
    @(negedge i_clk);
    i_abort = 1'b0;

    // Reset mid-run (together with abort): reset values, no done pulse.
    run_cmd(1'b0, 8'd5, 8'd3, 4'd10, 8'd0, 1'b0, 1'b0, 4'd0, 0, 0);
    @(negedge i_clk);
    @(negedge i_clk);
    i_rst = 1'b1; i_abort = 1'b1;
    @(negedge i_clk);
    i_rst = 1'b0; i_abort = 1'b0;
    chk("midrst_ready", {31'd0, o_ready}, 32'd1);
    chk("midrst_busy", {31'd0, o_busy}, 32'd0);
    chk("midrst_done", {31'd0, o_done}, 32'd0);
    chk("midrst_result", {24'd0, o_result}, 32'd0);
    chk("midrst_steps", {28'd0, o_steps}, 32'd0);
    chk("midrst_ovf", {31'd0, o_ovf}, 32'd0);
    chk("midrst_carry", {31'd0, o_carry}, 32'd0);
    repeat (3) @(negedge i_clk);
    chk("midrst_idle", {31'd0, o_ready}, 32'd1);

    n = 0;
    while (sb.size() != 0 && n < 50) begin
      @(negedge i_clk);
      n++;
    end
    chk("scoreboard_empty", sb.size(), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
